// File: rtl/bus_router.sv
// bus_router: one requester to NUM_DEVICES responders, routed by an 8-bit
// address tag. The decode is combinational, so a device can answer in the
// same cycle. Once a transaction stalls, the chosen device is latched and
// stays routed until it completes. The router answers unmapped addresses
// itself and keeps sticky error status.
// Optional build macro: BUS_ROUTER_TIMEOUT_EN. It adds a wait counter that
// aborts a transaction stuck in WAIT for TIMEOUT_CYCLES cycles.

// One decode lane: compares the address tag with this device's tag.
module bus_router_lane #(
   parameter logic [7:0] TAG = 8'h00
) (
   input  logic [7:0] addr_tag,
   output logic       match
);
   assign match = (addr_tag == TAG);
endmodule

module bus_router #(
   parameter int                        NUM_DEVICES    = 3,
   parameter logic [8*NUM_DEVICES-1:0]  DEV_TAGS       = {8'h81, 8'h80, 8'h00},
   parameter int                        TAG_LSB        = 24,
   parameter int                        TIMEOUT_CYCLES = 255,
   parameter logic [31:0]               ERROR_RDATA    = 32'h0,
   parameter logic [NUM_DEVICES-1:0]    IRQ_MASK       = '1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [31:0]                   req_address,
   input  logic [3:0]                    req_wstrobe,
   input  logic [31:0]                   req_wdata,
   output logic [31:0]                   req_rdata,
   output logic                          req_irq,
   output logic [NUM_DEVICES-1:0]        dev_valid,
   input  logic [NUM_DEVICES-1:0]        dev_ready,
   output logic [31:0]                   dev_address,
   output logic [3:0]                    dev_wstrobe,
   output logic [31:0]                   dev_wdata,
   input  logic [32*NUM_DEVICES-1:0]     dev_rdata,
   input  logic [NUM_DEVICES-1:0]        dev_irq,
   input  logic                          err_clear,
   output logic                          err_flag,
   output logic                          err_timeout,
   output logic [31:0]                   err_address
);

   localparam int SEL_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   typedef struct packed {
      logic             en;
      logic [SEL_W-1:0] idx;
   } route_t;

   // Catch out-of-range configurations at elaboration time.
   if (NUM_DEVICES < 1 || NUM_DEVICES > 16 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("bus_router: parameter out of range");
   end

   state_t                 state, state_n;
   logic [SEL_W-1:0]       sel, sel_n;
   logic [NUM_DEVICES-1:0] match;
   route_t                 hit, route;
   logic                   sel_ready;
   logic [31:0]            sel_rdata;
   logic                   timed_out;
   logic                   err_event;
`ifdef BUS_ROUTER_TIMEOUT_EN
   logic [15:0]            wait_cnt;
   logic                   cnt_clr;
   logic                   err_cause;
   logic                   err_to_q;
`endif

   // The request fields go to every device unchanged.
   assign dev_address = req_address;
   assign dev_wstrobe = req_wstrobe;
   assign dev_wdata   = req_wdata;

   assign req_irq = |(dev_irq & IRQ_MASK);

   for (genvar i = 0; i < NUM_DEVICES; i++) begin : g_lane
      bus_router_lane #(.TAG(DEV_TAGS[8*i +: 8])) u_lane (
         .addr_tag (req_address[TAG_LSB +: 8]),
         .match    (match[i])
      );
   end

   // Priority decode: scan from the top so that the lowest matching index wins.
   always_comb begin
      hit = '0;
      for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit.en  = 1'b1;
            hit.idx = SEL_W'(i);
         end
      end
   end

   // Active route: the live decode in IDLE, the latched select in WAIT.
   always_comb begin
      route = '0;
      if (reset) begin
         if (state == ST_WAIT) begin
            route.en  = 1'b1;
            route.idx = sel;
         end else if (req_valid && hit.en) begin
            route = hit;
         end
      end
   end

   // Return path mux: ready and read data from the routed device.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = ERROR_RDATA;
      for (int i = 0; i < NUM_DEVICES; i++) begin
         if (route.en && (SEL_W'(i) == route.idx)) begin
            sel_ready = dev_ready[i];
            sel_rdata = dev_rdata[32*i +: 32];
         end
      end
   end

`ifdef BUS_ROUTER_TIMEOUT_EN
   assign timed_out = (state == ST_WAIT) && (wait_cnt == 16'(TIMEOUT_CYCLES)) && !sel_ready;
`else
   assign timed_out = 1'b0;
`endif

   // Per-device valid. It is dropped in the cycle where a timeout aborts.
   always_comb begin
      dev_valid = '0;
      for (int i = 0; i < NUM_DEVICES; i++)
         dev_valid[i] = route.en && !timed_out && (SEL_W'(i) == route.idx);
   end

   // Next-state, handshake and error-event logic.
   always_comb begin
      state_n   = state;
      sel_n     = sel;
      req_ready = 1'b0;
      err_event = 1'b0;
`ifdef BUS_ROUTER_TIMEOUT_EN
      cnt_clr   = 1'b0;
      err_cause = 1'b0;
`endif
      if (reset) begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (hit.en) begin
                     req_ready = sel_ready;
                     if (!sel_ready) begin
                        state_n = ST_WAIT;
                        sel_n   = hit.idx;
`ifdef BUS_ROUTER_TIMEOUT_EN
                        cnt_clr = 1'b1;
`endif
                     end
                  end else begin
                     req_ready = 1'b1;
                     err_event = 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (timed_out) begin
                  req_ready = 1'b1;
                  err_event = 1'b1;
                  state_n   = ST_IDLE;
`ifdef BUS_ROUTER_TIMEOUT_EN
                  err_cause = 1'b1;
`endif
               end else begin
                  req_ready = sel_ready;
                  if (sel_ready) state_n = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // Read data counts only on a device completion. Errors and stalls return ERROR_RDATA.
   assign req_rdata = (req_ready && !err_event) ? sel_rdata : ERROR_RDATA;

   // State and latched select.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         sel   <= '0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
      end
   end

`ifdef BUS_ROUTER_TIMEOUT_EN
   // Wait counter saturates at the limit; it is cleared on entry to WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wait_cnt <= '0;
      else if (cnt_clr)
         wait_cnt <= '0;
      else if (state == ST_WAIT && wait_cnt < 16'(TIMEOUT_CYCLES))
         wait_cnt <= wait_cnt + 16'd1;
   end
`endif

   // Sticky error status. A new error takes priority over err_clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_flag    <= 1'b0;
         err_address <= '0;
`ifdef BUS_ROUTER_TIMEOUT_EN
         err_to_q    <= 1'b0;
`endif
      end else if (err_event) begin
         err_flag    <= 1'b1;
         err_address <= req_address;
`ifdef BUS_ROUTER_TIMEOUT_EN
         err_to_q    <= err_cause;
`endif
      end else if (err_clear) begin
         err_flag    <= 1'b0;
      end
   end

`ifdef BUS_ROUTER_TIMEOUT_EN
   assign err_timeout = err_to_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_router.sv
// Randomized scoreboard bench for bus_router. The driver pushes one expected
// response per transaction. The monitor checks each cycle at the falling edge
// against that entry and against an error-status model.
module tb_bus_router;

   localparam int          ND   = 3;
   localparam int          TO   = 4;
   localparam logic [31:0] ERRD = 32'h0;
`ifdef BUS_ROUTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      int          tgt;
      int          cycles;
      logic [31:0] rdata;
      bit          err;
      bit          abort;
      logic [31:0] addr;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [31:0]     req_address = '0;
   logic [3:0]      req_wstrobe = '0;
   logic [31:0]     req_wdata = '0;
   logic [31:0]     req_rdata;
   logic            req_irq;
   logic [ND-1:0]   dev_valid;
   logic [ND-1:0]   dev_ready = '0;
   logic [31:0]     dev_address;
   logic [3:0]      dev_wstrobe;
   logic [31:0]     dev_wdata;
   logic [32*ND-1:0] dev_rdata = '0;
   logic [ND-1:0]   dev_irq = '0;
   logic            err_clear = 1'b0;
   logic            err_flag;
   logic            err_timeout;
   logic [31:0]     err_address;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   bit   rnd = 1'b0;
   logic [7:0] tags [ND] = '{8'h00, 8'h80, 8'h81};

   bus_router #(.TIMEOUT_CYCLES(TO), .IRQ_MASK(3'b101)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_address(req_address), .req_wstrobe(req_wstrobe), .req_wdata(req_wdata),
      .req_rdata(req_rdata), .req_irq(req_irq), .dev_valid(dev_valid),
      .dev_ready(dev_ready), .dev_address(dev_address), .dev_wstrobe(dev_wstrobe),
      .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_irq(dev_irq),
      .err_clear(err_clear), .err_flag(err_flag), .err_timeout(err_timeout),
      .err_address(err_address)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // The first device whose tag equals t; -1 when no device has that tag.
   function automatic int lookup(input logic [7:0] t);
      for (int i = 0; i < ND; i++) if (tags[i] == t) return i;
      return -1;
   endfunction

   // Monitor and error-status model.
   int          cnt = 0;
   bit          m_flag = 0, m_to = 0;
   logic [31:0] m_addr = '0;
   always @(negedge clk) begin
      exp_t        e;
      int          c;
      bit          ev;
      logic [ND-1:0] exp_dv;
      if (!reset) begin
         cnt = 0; m_flag = 0; m_to = 0; m_addr = '0;
      end else begin
         ev = 0;
         chk("err_flag", {31'b0, err_flag}, {31'b0, m_flag});
         chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_to});
         chk("err_address", err_address, m_addr);
         chk("irq", {31'b0, req_irq}, {31'b0, dev_irq[0] || dev_irq[2]});
         chk("bcast_addr", dev_address, req_address);
         chk("bcast_wdata", dev_wdata, req_wdata);
         chk("bcast_wstrb", {28'b0, dev_wstrobe}, {28'b0, req_wstrobe});
         if (req_valid) begin
            if (sb.size() == 0) begin
               chk("sb_empty_ready", {31'b0, req_ready}, 32'h0);
            end else begin
               e = sb[0];
               c = cnt + 1;
               exp_dv = '0;
               if (e.tgt >= 0 && !(e.abort && c == e.cycles)) exp_dv[e.tgt] = 1'b1;
               chk("dev_valid", {29'b0, dev_valid}, {29'b0, exp_dv});
               chk("req_ready", {31'b0, req_ready}, {31'b0, c == e.cycles});
               chk("req_rdata", req_rdata, (c == e.cycles) ? e.rdata : ERRD);
               if (req_ready || c == e.cycles) begin
                  void'(sb.pop_front());
                  cnt = 0;
                  if (e.err && c == e.cycles) begin
                     ev = 1; m_addr = e.addr; m_to = e.abort;
                  end
               end else begin
                  cnt = c;
               end
            end
         end else begin
            chk("idle_dev_valid", {29'b0, dev_valid}, 32'h0);
            chk("idle_ready", {31'b0, req_ready}, 32'h0);
            chk("idle_rdata", req_rdata, ERRD);
         end
         if (ev) m_flag = 1;
         else if (err_clear) m_flag = 0;
      end
   end

   task automatic noise();
      dev_irq = ND'($urandom);
      dev_ready = ND'($urandom);
      err_clear = rnd && ($urandom_range(0, 7) == 0);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         noise();
         @(posedge clk); #1;
      end
      dev_ready = '0; err_clear = 1'b0;
   endtask

   // One transaction. delay = cycles before the target raises ready.
   // chg swaps the tag to 8'h80 in the second cycle.
   task automatic txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                      input int delay, input bit clr, input bit chg, input logic [31:0] rd0);
      exp_t e;
      bit   done;
      for (int i = 0; i < ND; i++) dev_rdata[32*i +: 32] = $urandom;
      if (rd0 != 0) dev_rdata[31:0] = rd0;
      e.tgt   = lookup(a[31:24]);
      e.addr  = a;
      e.abort = (e.tgt >= 0) && TO_EN && (delay > TO + 1);
      e.err   = (e.tgt < 0) || e.abort;
      e.cycles = (e.tgt < 0) ? 1 : (e.abort ? TO + 2 : delay + 1);
      e.rdata = e.err ? ERRD : dev_rdata[32*e.tgt +: 32];
      sb.push_back(e);
      req_address = a; req_wstrobe = ws; req_wdata = wd; req_valid = 1'b1;
      for (int k = 0; k < 400; k++) begin
         noise();
         if (k == 0 && clr) err_clear = 1'b1;
         if (e.tgt >= 0) dev_ready[e.tgt] = (k >= delay);
         if (chg && k == 1) req_address = {8'h80, a[23:0]};
         @(negedge clk);
         done = req_ready;
         @(posedge clk); #1;
         if (done) break;
         if (k == 399) chk("txn_bound", 32'h0, 32'h1);
      end
      req_valid = 1'b0; dev_ready = '0; err_clear = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          d;
      // Reset state: a live request to RAM must stay blocked during reset.
      req_valid = 1'b1; req_address = 32'h0000_0010; dev_ready = '1;
      #12;
      chk("rst_dev_valid", {29'b0, dev_valid}, 32'h0);
      chk("rst_ready", {31'b0, req_ready}, 32'h0);
      chk("rst_err_flag", {31'b0, err_flag}, 32'h0);
      chk("rst_err_addr", err_address, 32'h0);
      chk("rst_err_to", {31'b0, err_timeout}, 32'h0);
      req_valid = 1'b0; dev_ready = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);

      // RAM read that completes in the first cycle.
      txn(32'h0000_0010, 4'h0, 32'h0, 0, 0, 0, 32'hCAFE_0001);
      // UART write whose ready arrives after 3 cycles; the tag changes mid-wait.
      txn(32'h8100_0004, 4'hF, 32'h1234_5678, 3, 0, 1, 32'h0);
      idle(1);
      // Unmapped read, followed by an err_clear pulse.
      txn(32'h4200_0000, 4'h0, 32'h0, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk("unm_flag", {31'b0, err_flag}, 32'h1);
      chk("unm_to", {31'b0, err_timeout}, 32'h0);
      chk("unm_addr", err_address, 32'h4200_0000);
      @(posedge clk); #1;
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      @(negedge clk);
      chk("clr_flag", {31'b0, err_flag}, 32'h0);
      chk("clr_addr", err_address, 32'h4200_0000);
      @(posedge clk); #1;

      if (TO_EN) begin
         // Timer never answers; the router aborts and a RAM access follows.
         txn(32'h8000_0000, 4'h0, 32'h0, 1000, 0, 0, 32'h0);
         @(negedge clk);
         chk("to_flag", {31'b0, err_flag}, 32'h1);
         chk("to_cause", {31'b0, err_timeout}, 32'h1);
         chk("to_addr", err_address, 32'h8000_0000);
         @(posedge clk); #1;
         txn(32'h0000_0020, 4'h0, 32'h0, 1, 0, 0, 32'hBEEF_0002);
      end

      // Reset in the second WAIT cycle. Outputs must drop at once and err_* must clear.
      begin
         exp_t e;
         e.tgt = 0; e.cycles = 1000; e.rdata = ERRD; e.err = 0; e.abort = 0; e.addr = 0;
         sb.push_back(e);
         req_address = 32'h0000_0040; req_wstrobe = 4'h0; req_valid = 1'b1; dev_ready = '0;
         @(posedge clk); #1;
         @(posedge clk); #3;
         reset = 1'b0;
         #1;
         chk("midrst_dev_valid", {29'b0, dev_valid}, 32'h0);
         chk("midrst_ready", {31'b0, req_ready}, 32'h0);
         req_valid = 1'b0;
         do_reset();
         @(negedge clk);
         chk("post_rst_flag", {31'b0, err_flag}, 32'h0);
         chk("post_rst_to", {31'b0, err_timeout}, 32'h0);
         chk("post_rst_addr", err_address, 32'h0);
         @(posedge clk); #1;
      end

      // An error arriving with err_clear in the same cycle wins; masked IRQ.
      txn(32'h0000_0000, 4'h0, 32'h0, 0, 0, 0, 32'h0);
      txn(32'hFF00_0000, 4'h0, 32'h0, 0, 1, 0, 32'h0);
      dev_irq = 3'b010;
      @(negedge clk);
      chk("clr_vs_err_flag", {31'b0, err_flag}, 32'h1);
      chk("clr_vs_err_addr", err_address, 32'hFF00_0000);
      chk("irq_masked", {31'b0, req_irq}, 32'h0);
      @(posedge clk); #1;

      // Random traffic.
      rnd = 1'b1;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0: a = {8'h00, 24'($urandom)};
            1: a = {8'h80, 24'($urandom)};
            2: a = {8'h81, 24'($urandom)};
            default: a = $urandom;
         endcase
         d = $urandom_range(0, 7);
         txn(a, 4'($urandom), $urandom, d, 0, ($urandom_range(0, 3) == 0), 32'h0);
         idle($urandom_range(0, 2));
      end
      rnd = 1'b0;
      idle(2);
      chk("sb_drained", sb.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
